// File: rtl/upg_loader.sv
// UART program loader: length-prefixed word frames into instruction memory.
// Optional trailing XOR checksum byte when UPG_CHECKSUM_EN is defined.
module upg_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        upg_wen_o,
  output logic [13:0] upg_addr_o,
  output logic [31:0] upg_data_o,
  output logic        upg_done_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
`ifdef UPG_CHECKSUM_EN
    S_CSUM   = 3'd4,
`endif
    S_DONE   = 3'd5
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [7:0]    len_lo;
  logic [14:0]   remaining;
  logic [13:0]   addr;
  logic [1:0]    idx;
  logic [31:0]   asm_q;
  logic [TW-1:0] tmo;
  logic          wen_q;
  logic          done_q;
  logic          err_q;
`ifdef UPG_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  logic          timed;
  logic          tmo_hit;
  logic          take;
  logic          wr;
  logic          err_set;
  logic [15:0]   n_word;
  logic [31:0]   word;

  assign n_word = {rx_data_i, len_lo};
  assign word   = {rx_data_i, asm_q[31:8]};

  always_comb begin
    timed = 1'b0;
    unique case (1'b1)
      state == S_LEN_HI: timed = 1'b1;
      state == S_DATA:   timed = 1'b1;
`ifdef UPG_CHECKSUM_EN
      state == S_CSUM:   timed = 1'b1;
`endif
      default:           timed = 1'b0;
    endcase
  end

  assign tmo_hit = timed && !rx_valid_i && (tmo == TMO_LAST);

  always_comb begin
    state_n = state;
    take    = 1'b0;
    wr      = 1'b0;
    err_set = 1'b0;
    if (start_i) begin
      state_n = S_LEN_LO;
    end else if (tmo_hit) begin
      state_n = S_IDLE;
      err_set = 1'b1;
    end else if (rx_valid_i) begin
      unique case (state)
        S_LEN_LO: state_n = S_LEN_HI;
        S_LEN_HI: begin
          if (n_word == 16'd0) begin
            state_n = S_DONE;
          end else if (n_word > 16'd16384) begin
            state_n = S_IDLE;
            err_set = 1'b1;
          end else begin
            state_n = S_DATA;
          end
        end
        S_DATA: begin
          take = 1'b1;
          if (idx == 2'd3) begin
            wr = 1'b1;
            if (remaining == 15'd1) begin
`ifdef UPG_CHECKSUM_EN
              state_n = S_CSUM;
`else
              state_n = S_DONE;
`endif
            end
          end
        end
`ifdef UPG_CHECKSUM_EN
        S_CSUM: begin
          if (rx_data_i == csum) begin
            state_n = S_DONE;
          end else begin
            state_n = S_IDLE;
            err_set = 1'b1;
          end
        end
`endif
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo     <= '0;
      remaining  <= '0;
      addr       <= '0;
      idx        <= '0;
      asm_q      <= '0;
      tmo        <= '0;
      wen_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      upg_addr_o <= '0;
      upg_data_o <= '0;
`ifdef UPG_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      wen_q <= wr;
      if (start_i) begin
        err_q  <= 1'b0;
        done_q <= 1'b0;
        addr   <= '0;
        idx    <= '0;
        tmo    <= '0;
`ifdef UPG_CHECKSUM_EN
        csum   <= '0;
`endif
      end else begin
        if (err_set) err_q <= 1'b1;
        if (state == S_DONE) done_q <= 1'b1;
        // Idle-gap counter; any accepted byte restarts the window
        if (!timed || rx_valid_i || tmo_hit) begin
          tmo <= '0;
        end else begin
          tmo <= tmo + 1'b1;
        end
        if (state == S_LEN_LO && rx_valid_i) begin
          len_lo <= rx_data_i;
        end
        if (state == S_LEN_HI && rx_valid_i) begin
          remaining <= n_word[14:0];
        end
        if (take) begin
          asm_q <= word;
          idx   <= idx + 2'd1;
`ifdef UPG_CHECKSUM_EN
          csum  <= csum ^ rx_data_i;
`endif
        end
        if (wr) begin
          upg_data_o <= word;
          upg_addr_o <= addr;
          addr       <= addr + 14'd1;
          remaining  <= remaining - 15'd1;
        end
      end
    end
  end

  // Reset kills a pending write pulse in the very cycle it arrives
  assign upg_wen_o  = wen_q & rst_n;
  assign upg_done_o = done_q;
  assign err_o      = err_q;
  assign busy_o     = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: doc/upg_loader.md
UPG_LOADER -- requirements
Module: upg_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000: max idle clk cycles between bytes inside a frame before abort.
REQ-002 Port clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port start_i  input  1  one-cycle pulse: arm loader for a new frame; aborts any frame in progress.
REQ-005 Port rx_data_i  input  8  byte from UART receiver.
REQ-006 Port rx_valid_i  input  1  one-cycle strobe; rx_data_i valid this cycle.
REQ-007 Port upg_wen_o  output  1  instruction-memory write enable, one-cycle pulse per word.
REQ-008 Port upg_addr_o  output  14  word address of current write.
REQ-009 Port upg_data_o  output  32  word to write.
REQ-010 Port upg_done_o  output  1  level; program load complete.
REQ-011 Port busy_o  output  1  high in any state other than IDLE and DONE.
REQ-012 Port err_o  output  1  level; last frame aborted (timeout, bad length, checksum).

Function
REQ-013 Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N words of 4 bytes each, little-endian (first byte = bits 7:0).
REQ-014 States: IDLE, LEN_LO, LEN_HI, DATA, CSUM (macro only), DONE.
REQ-015 IDLE/DONE --start_i--> LEN_LO; clears err_o and upg_done_o, zeroes the address counter, the byte index and the timeout counter.
REQ-016 In IDLE and DONE, rx_valid_i is ignored.
REQ-017 LEN_LO --rx_valid_i--> LEN_HI; LEN_HI --rx_valid_i--> DATA if 0<N<=16384, DONE if N==0, IDLE with err_o=1 if N>16384.
REQ-018 DATA: each accepted byte is shifted into a 32-bit assembly register; the 2-bit byte index wraps 3->0.
REQ-019 On acceptance of the 4th byte of a word: next cycle upg_wen_o=1 for exactly one cycle, upg_data_o = assembled word, upg_addr_o = current word address; the address then increments by 1.
REQ-020 Bytes are accepted on every rx_valid_i cycle in DATA, including the cycle upg_wen_o is high; no byte is dropped.
REQ-021 After write of word N-1: enter DONE (or CSUM with the macro) in the same cycle as the final upg_wen_o pulse; upg_done_o=1 from the next cycle.
REQ-022 upg_addr_o and upg_data_o hold their last values between pulses.
REQ-023 Address arithmetic is 14-bit; N=16384 writes addresses 0..16383 with no wrap-around write.
REQ-024 Timeout counter is cleared on each accepted byte and increments each cycle in LEN_LO (after first byte: no), LEN_HI, DATA and CSUM; reaching TIMEOUT_CYCLES -> IDLE, err_o=1, no further writes. LEN_LO waits indefinitely.
REQ-025 start_i asserted together with rx_valid_i: start_i wins; the byte is discarded.
REQ-026 start_i mid-frame: abort immediately; no pending upg_wen_o pulse is issued; restart at LEN_LO.

Reset
REQ-027 rst_n low: state=IDLE; upg_wen_o=0, upg_addr_o=0, upg_data_o=0, upg_done_o=0, busy_o=0, err_o=0; all counters are cleared.
REQ-028 Reset asserted mid-frame cancels any pending write pulse in the same cycle.

Configuration
REQ-029 Macro UPG_CHECKSUM_EN defined: one byte follows the last word, equal to the XOR of all data bytes; state CSUM compares it; match -> DONE, mismatch -> IDLE with err_o=1 (words already written stay written).
REQ-030 Macro UPG_CHECKSUM_EN undefined: no CSUM state and no checksum byte; DONE directly after the last write.

Verification
REQ-031 start, bytes 02 00 78 56 34 12 EF BE AD DE -> wen pulses: addr 0 data 0x12345678, addr 1 data 0xDEADBEEF; upg_done_o=1.
REQ-032 start, bytes 00 00 -> zero wen pulses, upg_done_o=1, err_o=0.
REQ-033 start, bytes 01 00 AA BB, then a silence of TIMEOUT_CYCLES -> no wen pulse, IDLE, err_o=1.
REQ-034 start, bytes 01 40 -> err_o=1, IDLE, no wen pulse.
REQ-035 rst_n low one cycle after the 4th data byte -> no wen pulse; all outputs 0.
REQ-036 UPG_CHECKSUM_EN: 01 00 01 02 03 04 then 04 -> done; the same frame with 05 -> err_o=1 after the single write at addr 0.
